// File: rtl/pll_lock_sequencer.sv
// Sequences the iCE40 PLL out of reset on the 12 MHz reference clock and releases sys_reset once lock is stable.
// Outputs are registered from the next state; a lock loss or relock_req re-runs the whole sequence.
module pll_lock_sequencer #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int COUNT_WIDTH   = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   pll_locked,
   input  logic                   relock_req,
   output logic                   pll_resetb,
   output logic                   sys_reset,
   output logic                   ready,
   output logic [COUNT_WIDTH-1:0] retry_count,
   output logic [COUNT_WIDTH-1:0] lost_count,
   output logic [1:0]             state
);

   localparam int MAX_AB     = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYCLES = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int TW         = $clog2(MAX_CYCLES) + 1;

   localparam logic [TW-1:0]          RST_LAST    = TW'(RESET_CYCLES - 1);
   localparam logic [TW-1:0]          LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0]          STABLE_LAST = TW'(STABLE_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [COUNT_WIDTH-1:0] retry_q, retry_d;
   logic [COUNT_WIDTH-1:0] lost_q, lost_d;
   logic                   lk_meta_q, lk_meta_d;
   logic                   lk_q, lk_d;
   logic                   pll_resetb_q, pll_resetb_d;
   logic                   sys_reset_q, sys_reset_d;
   logic                   ready_q, ready_d;

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + COUNT_WIDTH'(1);
   endfunction

   always_comb begin
      lk_meta_d = pll_locked;
      lk_d      = lk_meta_q;
      state_d   = state_q;
      timer_d   = timer_q + TW'(1);
      retry_d   = retry_q;
      lost_d    = lost_q;

      case (state_q)
         PLL_RST: begin
            // relock_req is deliberately ignored here so the pulse length never stretches
            if (timer_q == RST_LAST) begin
               state_d = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            if (relock_req) begin
               state_d = PLL_RST;
            end else if (lk_q) begin
               state_d = STABLE;
            end else if (timer_q == LOCK_LAST) begin
               state_d = PLL_RST;
               retry_d = sat_inc(retry_q);
            end
         end
         STABLE: begin
            if (relock_req) begin
               state_d = PLL_RST;
            end else if (!lk_q) begin
               state_d = WAIT_LOCK;
            end else if (timer_q == STABLE_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            timer_d = timer_q;
            // A lock loss is counted even when a relock request lands on the same cycle
            if (!lk_q) begin
               state_d = PLL_RST;
               lost_d  = sat_inc(lost_q);
            end else if (relock_req) begin
               state_d = PLL_RST;
            end
         end
         default: begin
            state_d = PLL_RST;
         end
      endcase

      if (state_d != state_q) begin
         timer_d = '0;
      end

      pll_resetb_d = (state_d != PLL_RST);
      sys_reset_d  = (state_d != RUN);
      ready_d      = (state_d == RUN);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= PLL_RST;
         timer_q      <= '0;
         retry_q      <= '0;
         lost_q       <= '0;
         lk_meta_q    <= 1'b0;
         lk_q         <= 1'b0;
         pll_resetb_q <= 1'b0;
         sys_reset_q  <= 1'b1;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         retry_q      <= retry_d;
         lost_q       <= lost_d;
         lk_meta_q    <= lk_meta_d;
         lk_q         <= lk_d;
         pll_resetb_q <= pll_resetb_d;
         sys_reset_q  <= sys_reset_d;
         ready_q      <= ready_d;
      end
   end

   assign pll_resetb  = pll_resetb_q;
   assign sys_reset   = sys_reset_q;
   assign ready       = ready_q;
   assign retry_count = retry_q;
   assign lost_count  = lost_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: timestamped reference model feeds a scoreboard that a monitor drains on every output change.
module tb_pll_lock_sequencer;

   localparam int RC   = 4;
   localparam int LT   = 32;
   localparam int SC   = 8;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          pll_locked;
   logic          relock_req;
   logic          pll_resetb;
   logic          sys_reset;
   logic          ready;
   logic [CW-1:0] retry_count;
   logic [CW-1:0] lost_count;
   logic [1:0]    state;

   pll_lock_sequencer #(
      .RESET_CYCLES (RC),
      .LOCK_TIMEOUT (LT),
      .STABLE_CYCLES(SC),
      .COUNT_WIDTH  (CW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .pll_locked (pll_locked),
      .relock_req (relock_req),
      .pll_resetb (pll_resetb),
      .sys_reset  (sys_reset),
      .ready      (ready),
      .retry_count(retry_count),
      .lost_count (lost_count),
      .state      (state)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         edge_no;
      logic [8:0] snap;
   } rec_t;

   rec_t       sbq[$];
   rec_t       mon_e;
   logic [8:0] prev_snap;
   logic [8:0] dut_snap;
   int         n_checks = 0;
   int         n_fail   = 0;

   // Model: edges counted from reset release; time in a state is (edge - entry edge)
   int   cyc      = 0;
   int   m_state  = 0;
   int   m_enter  = 0;
   int   m_retry  = 0;
   int   m_lost   = 0;
   logic m_p1     = 1'b0;
   logic m_p2     = 1'b0;

   assign dut_snap = {state, pll_resetb, sys_reset, ready, retry_count, lost_count};

   function automatic logic [8:0] snap_of(input int st, input int rc, input int lc);
      logic [1:0]    s;
      logic [CW-1:0] r;
      logic [CW-1:0] l;
      s = st[1:0];
      r = rc[CW-1:0];
      l = lc[CW-1:0];
      return {s, (st != 0), (st != 3), (st == 3), r, l};
   endfunction

   always @(negedge clock) begin
      if (reset) begin
         prev_snap = snap_of(0, 0, 0);
      end else if (dut_snap !== prev_snap) begin
         n_checks++;
         if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output edge=%0d got=%b required=no change from %b", cyc, dut_snap, prev_snap);
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.edge_no != cyc || mon_e.snap !== dut_snap) begin
               n_fail++;
               $display("FAIL output_event got edge=%0d snap=%b required edge=%0d snap=%b",
                        cyc, dut_snap, mon_e.edge_no, mon_e.snap);
            end
         end
         prev_snap = dut_snap;
      end
   end

   task automatic step(input logic p, input logic r);
      int   n;
      int   nxt;
      int   in_state;
      logic lk;
      rec_t rec;
      n        = cyc + 1;
      lk       = m_p2;
      nxt      = m_state;
      in_state = n - m_enter;
      case (m_state)
         0: begin
            if (in_state == RC) nxt = 1;
         end
         1: begin
            if (r) nxt = 0;
            else if (lk) nxt = 2;
            else if (in_state == LT) begin
               nxt = 0;
               if (m_retry < CMAX) m_retry++;
            end
         end
         2: begin
            if (r) nxt = 0;
            else if (!lk) nxt = 1;
            else if (in_state == SC) nxt = 3;
         end
         default: begin
            if (!lk) begin
               nxt = 0;
               if (m_lost < CMAX) m_lost++;
            end else if (r) nxt = 0;
         end
      endcase
      if (nxt != m_state) begin
         m_state     = nxt;
         m_enter     = n;
         rec.edge_no = n;
         rec.snap    = snap_of(m_state, m_retry, m_lost);
         sbq.push_back(rec);
      end
      m_p2       = m_p1;
      m_p1       = p;
      pll_locked = p;
      relock_req = r;
      @(posedge clock);
      #1;
      cyc = n;
   endtask

   task automatic hold(input logic p, input int n);
      for (int i = 0; i < n; i++) step(p, 1'b0);
   endtask

   task automatic check_drained();
      n_checks++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending_events=%0d required=0 (next edge=%0d)", sbq.size(), sbq[0].edge_no);
      end
      sbq.delete();
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      check_drained();
      reset      = 1'b1;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      #2;
      n_checks++;
      if (dut_snap !== snap_of(0, 0, 0)) begin
         n_fail++;
         $display("FAIL reset_values got=%b required=%b", dut_snap, snap_of(0, 0, 0));
      end
      repeat (3) @(posedge clock);
      #1;
      reset   = 1'b0;
      cyc     = 0;
      m_state = 0;
      m_enter = 0;
      m_retry = 0;
      m_lost  = 0;
      m_p1    = 1'b0;
      m_p2    = 1'b0;
   endtask

   initial begin
      logic p;
      int   len;
      reset      = 1'b1;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      do_reset();

      // Normal lock, then lock loss with a full rerun
      hold(1'b0, 10);
      hold(1'b1, 20);
      hold(1'b0, 3);
      hold(1'b1, 30);

      // relock in RUN, then a second pulse while the PLL is held in reset
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      hold(1'b1, 30);

      // Lock loss and relock_req land on the same edge in RUN
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      hold(1'b1, 30);

      // Two more losses push lost_count into saturation
      for (int k = 0; k < 2; k++) begin
         hold(1'b0, 3);
         hold(1'b1, 30);
      end

      // One-cycle glitch at the fifth STABLE cycle
      do_reset();
      hold(1'b0, 10);
      hold(1'b1, 5);
      step(1'b0, 1'b0);
      hold(1'b1, 20);

      // Five back-to-back timeouts saturate retry_count
      do_reset();
      hold(1'b0, 5 * (RC + LT) + 10);
      hold(1'b1, 20);

      for (int s = 0; s < 40; s++) begin
         p   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 45);
         for (int i = 0; i < len; i++) step(p, ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 9) == 0) do_reset();
      end

      hold(1'b1, 3);
      @(negedge clock);
      #1;
      check_drained();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
